// File: rtl/reg_file_sb.sv
// 32 x 32 register file with a write-first bypass on both read ports, a debug read port,
// and a per-register busy scoreboard that decode sets and write-back clears.
module reg_file_sb #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    input  logic          we,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    input  logic          rsv_en,
    input  logic [AW-1:0] rsv_addr,
    output logic          rs_busy,
    output logic          rt_busy,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic [AW:0]   busy_cnt
);

    localparam int NREG = 2**AW;

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;
    logic [AW:0]     cnt_next;
    logic            wr_ok;

    assign wr_ok = we && (w_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[w_addr] <= w_data;
        end
    end

    // Clear is applied before set so a same-cycle reissue keeps the register busy.
    always_comb begin
        sb_next = sb;
        if (wr_ok) sb_next[w_addr] = 1'b0;
        if (rsv_en && (rsv_addr != '0)) sb_next[rsv_addr] = 1'b1;
        cnt_next = '0;
        for (int i = 0; i < NREG; i++) cnt_next = cnt_next + {{AW{1'b0}}, sb_next[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb       <= '0;
            busy_cnt <= '0;
        end else begin
            sb       <= sb_next;
            busy_cnt <= cnt_next;
        end
    end

    always_comb begin
        rs_data = '0;
        if (rs_addr != '0) rs_data = (we && (w_addr == rs_addr)) ? w_data : regs[rs_addr];
        rt_data = '0;
        if (rt_addr != '0) rt_data = (we && (w_addr == rt_addr)) ? w_data : regs[rt_addr];
        dbg_data = (dbg_addr != '0) ? regs[dbg_addr] : '0;
    end

    // A register being written back this cycle is served by the bypass, so it is not busy.
    assign rs_busy = (rs_addr != '0) && sb[rs_addr] && !(we && (w_addr == rs_addr));
    assign rt_busy = (rt_addr != '0) && sb[rt_addr] && !(we && (w_addr == rt_addr));

endmodule
